pipeline_redirect_ctrl: RTL and testbench

Central hazard sequencer for the 5-stage pipeline. Arbitrates same-cycle redirect and stall requests: exception/eret/syscall from MEM, taken branch/jump from EX, load-use from ID. Drives PC mux select/target and per-stage stall/flush, then holds a fixed bubble-drain window after each redirect. Sits between the hazard detectors and the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/pipeline_redirect_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_redirect_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_redirect_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: arbitrates exception, branch and
// load-use requests, drives PC select/target, stalls and flushes, and drains bubbles.
module pipeline_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 2,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_target,
  input  logic              exc_req,
  input  logic [XLEN-1:0]   exc_target,
  input  logic              load_use,
  output logic [1:0]        pc_sel,
  output logic [XLEN-1:0]   pc_target,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              busy,
  output logic [CNT_W-1:0]  bubbles_left,
  output logic [STAT_W-1:0] stat_bubbles
);

  typedef enum logic [1:0] {RUN, BR_DRAIN, EXC_DRAIN} state_t;

  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(FLUSH_CYCLES - 1);
  localparam bit               DRAINED = (FLUSH_CYCLES > 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAT_W-1:0]  stat_q, stat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_sel       = 2'd0;
    pc_target    = '0;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;

    if (exc_req) begin
      // Exceptions preempt everything, including an in-progress drain.
      pc_sel       = 2'd2;
      pc_target    = exc_target;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      state_d      = DRAINED ? EXC_DRAIN : RUN;
      cnt_d        = DRAINED ? RELOAD : '0;
    end else if (state_q == RUN) begin
      if (br_taken) begin
        pc_sel      = 2'd1;
        pc_target   = br_target;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        state_d     = DRAINED ? BR_DRAIN : RUN;
        cnt_d       = DRAINED ? RELOAD : '0;
      end else if (load_use) begin
        stall_if    = 1'b1;
        stall_id    = 1'b1;
        flush_id_ex = 1'b1;
      end
    end else begin
      // Drain: branch/load-use come from squashed slots and are ignored.
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = (state_q == EXC_DRAIN);
      if (cnt_q <= CNT_W'(1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    stat_d = stat_q;
    if (flush_id_ex && (stat_q != '1)) stat_d = stat_q + STAT_W'(1);

    // Keep the combinational outputs quiet while reset is held.
    if (!rst_n) begin
      pc_sel       = 2'd0;
      pc_target    = '0;
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
    end
  end

  assign busy         = (state_q != RUN);
  assign bubbles_left = busy ? cnt_q : '0;
  assign stat_bubbles = stat_q;

endmodule

// File: tb/tb_pipeline_redirect_ctrl.sv
// Bench for pipeline_redirect_ctrl: vector table through a scoreboard queue,
// plus reset-mid-drain and statistic-saturation sequences.
module tb_pipeline_redirect_ctrl;
  localparam int XLEN = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             br_taken, exc_req, load_use;
  logic [XLEN-1:0]  br_target, exc_target;
  logic [1:0]       pc_sel;
  logic [XLEN-1:0]  pc_target;
  logic             stall_if, stall_id, flush_if_id, flush_id_ex, flush_ex_mem, busy;
  logic [1:0]       bubbles_left;
  logic [15:0]      stat_bubbles;

  int checks = 0;
  int errors = 0;

  pipeline_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .br_taken(br_taken), .br_target(br_target),
    .exc_req(exc_req), .exc_target(exc_target),
    .load_use(load_use),
    .pc_sel(pc_sel), .pc_target(pc_target),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .busy(busy), .bubbles_left(bubbles_left), .stat_bubbles(stat_bubbles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;  logic [31:0] bt;
    logic        exc; logic [31:0] et;
    logic        lu;
    logic [1:0]  sel; logic [31:0] tgt;
    logic        sif, sid, fifid, fidex, fexmem, bsy;
    logic [1:0]  bl;
  } vec_t;

  typedef struct {
    logic [1:0]  sel; logic [31:0] tgt;
    logic        sif, sid, fifid, fidex, fexmem, bsy;
    logic [1:0]  bl;
    logic [15:0] stat;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   exp_stat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs(input exp_t e, input string tag);
    chk({tag, ".pc_sel"},       32'(pc_sel),       32'(e.sel));
    chk({tag, ".pc_target"},    pc_target,         e.tgt);
    chk({tag, ".stall_if"},     32'(stall_if),     32'(e.sif));
    chk({tag, ".stall_id"},     32'(stall_id),     32'(e.sid));
    chk({tag, ".flush_if_id"},  32'(flush_if_id),  32'(e.fifid));
    chk({tag, ".flush_id_ex"},  32'(flush_id_ex),  32'(e.fidex));
    chk({tag, ".flush_ex_mem"}, 32'(flush_ex_mem), 32'(e.fexmem));
    chk({tag, ".busy"},         32'(busy),         32'(e.bsy));
    chk({tag, ".bubbles_left"}, 32'(bubbles_left), 32'(e.bl));
    chk({tag, ".stat_bubbles"}, 32'(stat_bubbles), 32'(e.stat));
  endtask

  function automatic vec_t mk(logic br, logic [31:0] bt, logic exc, logic [31:0] et, logic lu,
                              logic [1:0] sel, logic [31:0] tgt, logic sif, logic sid,
                              logic fifid, logic fidex, logic fexmem, logic bsy, logic [1:0] bl);
    vec_t v;
    v.br = br; v.bt = bt; v.exc = exc; v.et = et; v.lu = lu;
    v.sel = sel; v.tgt = tgt; v.sif = sif; v.sid = sid;
    v.fifid = fifid; v.fidex = fidex; v.fexmem = fexmem; v.bsy = bsy; v.bl = bl;
    return v;
  endfunction

  // Drive one vector at the falling edge, queue its expectation, sample before the rising edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e, got;
    @(negedge clk);
    br_taken = v.br; br_target = v.bt; exc_req = v.exc; exc_target = v.et; load_use = v.lu;
    e.sel = v.sel; e.tgt = v.tgt; e.sif = v.sif; e.sid = v.sid; e.fifid = v.fifid;
    e.fidex = v.fidex; e.fexmem = v.fexmem; e.bsy = v.bsy; e.bl = v.bl;
    e.stat = 16'(exp_stat);
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    compare_outputs(got, $sformatf("vec%0d", idx));
    if (v.fidex && exp_stat < 65535) exp_stat++;
  endtask

  task automatic idle_inputs();
    br_taken = 0; br_target = '0; exc_req = 0; exc_target = '0; load_use = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #2;
    rst_n = 1;
    exp_stat = 0;
  endtask

  localparam logic [31:0] BT  = 32'h0040_0020;
  localparam logic [31:0] ET  = 32'h8000_0180;

  initial begin
    exp_t z;
    rst_n = 0;
    idle_inputs();
    exp_stat = 0;
    #3;
    z = '{sel: 2'd0, tgt: 32'd0, sif: 0, sid: 0, fifid: 0, fidex: 0, fexmem: 0, bsy: 0, bl: 2'd0, stat: 16'd0};
    compare_outputs(z, "reset");
    @(negedge clk);
    rst_n = 1;

    //                br bt  exc et  lu  sel  tgt  sif sid fif fid fem bsy bl
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  0,  0,  0,  0,  2'd0));
    tbl.push_back(mk(1, BT, 0, 0,  0,  2'd1, BT,  0,  0,  1,  1,  0,  0,  2'd0));
    tbl.push_back(mk(1, BT, 0, 0,  1,  2'd0, 0,   0,  0,  1,  1,  0,  1,  2'd2));
    tbl.push_back(mk(0, 0,  0, 0,  1,  2'd0, 0,   0,  0,  1,  1,  0,  1,  2'd1));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  0,  0,  0,  0,  2'd0));
    tbl.push_back(mk(0, 0,  0, 0,  1,  2'd0, 0,   1,  1,  0,  1,  0,  0,  2'd0));
    tbl.push_back(mk(0, 0,  0, 0,  1,  2'd0, 0,   1,  1,  0,  1,  0,  0,  2'd0));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  0,  0,  0,  0,  2'd0));
    tbl.push_back(mk(1, BT, 1, ET, 1,  2'd2, ET,  0,  0,  1,  1,  1,  0,  2'd0));
    tbl.push_back(mk(1, BT, 0, 0,  0,  2'd0, 0,   0,  0,  1,  1,  1,  1,  2'd2));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  1,  1,  1,  1,  2'd1));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  0,  0,  0,  0,  2'd0));
    tbl.push_back(mk(1, BT, 0, 0,  0,  2'd1, BT,  0,  0,  1,  1,  0,  0,  2'd0));
    tbl.push_back(mk(0, 0,  1, ET, 0,  2'd2, ET,  0,  0,  1,  1,  1,  1,  2'd2));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  1,  1,  1,  1,  2'd2));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  1,  1,  1,  1,  2'd1));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  0,  0,  0,  0,  2'd0));
    tbl.push_back(mk(0, 0,  1, ET, 0,  2'd2, ET,  0,  0,  1,  1,  1,  0,  2'd0));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  1,  1,  1,  1,  2'd2));
    tbl.push_back(mk(0, 0,  1, ET, 0,  2'd2, ET,  0,  0,  1,  1,  1,  1,  2'd1));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  1,  1,  1,  1,  2'd2));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  1,  1,  1,  1,  2'd1));
    tbl.push_back(mk(0, 0,  0, 0,  0,  2'd0, 0,   0,  0,  0,  0,  0,  0,  2'd0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset asserted during the first drain cycle of a branch.
    @(negedge clk);
    br_taken = 1; br_target = 32'h0040_0040;
    #2;
    chk("mid.redirect_sel", 32'(pc_sel), 32'd1);
    @(negedge clk);
    #1;
    chk("mid.busy_before_reset", 32'(busy), 32'd1);
    rst_n = 0;
    #1;
    z = '{sel: 2'd0, tgt: 32'd0, sif: 0, sid: 0, fifid: 0, fidex: 0, fexmem: 0, bsy: 0, bl: 2'd0, stat: 16'd0};
    compare_outputs(z, "mid_reset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    exp_stat = 0;
    @(negedge clk);
    #2;
    compare_outputs(z, "after_release");

    // Saturate the bubble statistic with a long load-use run.
    do_reset();
    @(negedge clk);
    load_use = 1;
    for (int i = 0; i < 65534; i++) @(negedge clk);
    #1;
    chk("sat.near_max", 32'(stat_bubbles), 32'h0000_FFFE);
    for (int i = 0; i < 6; i++) @(negedge clk);
    #1;
    chk("sat.hold", 32'(stat_bubbles), 32'h0000_FFFF);
    chk("sat.stall_if", 32'(stall_if), 32'd1);
    @(negedge clk);
    #1;
    chk("sat.no_wrap", 32'(stat_bubbles), 32'h0000_FFFF);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish before 2000000");
    $fatal(1);
  end

endmodule
